// File: rtl/iq_stream_packer_if.sv
// Word stream from the I/Q packer into the stream-to-AXI bridge.
// The packer drives the bus (master); the bridge consumes it (slave).
interface iq_stream_packer_if;
    logic [31:0] Sout;   // packed word, bridge Sin
    logic        Ien;    // one-cycle word strobe
    logic        sync;   // one-cycle capture-start pulse

    modport master (output Sout, Ien, sync);
    modport slave  (input  Sout, Ien, sync);
endinterface

// File: rtl/iq_stream_packer.sv
// Packs receive I/Q samples into 32-bit words for the stream-to-AXI capture
// path. A capture is bracketed by en, can decimate (keep 1 of dec+1 valid
// samples) and can compress two samples per word (8 MSBs of each component).
// Every capture is padded with zero words up to a whole AXI burst so the
// bridge never holds a partial burst.
module iq_stream_packer #(
    parameter int DW         = 12,  // sample width, 9..16
    parameter int BURST_LOG2 = 4    // log2 of words per AXI burst
) (
    input  logic                      Sclk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      mode,
    input  logic [7:0]                dec,
    input  logic                      rx_valid,
    input  logic [DW-1:0]             rx_i,
    input  logic [DW-1:0]             rx_q,
    iq_stream_packer_if.master        bus,
    output logic                      busy,
    output logic [31:0]               wcnt
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                state;
    logic                  mode_r;     // capture mode latched at sync
    logic [7:0]            dec_r;      // decimation ratio latched at sync
    logic [7:0]            dcnt;       // valid samples still to skip
    logic [15:0]           pend;       // first compressed sample {Q msb8, I msb8}
    logic                  pend_vld;

    logic [15:0]           i_wide;
    logic [15:0]           q_wide;
    logic [7:0]            i_msb;
    logic [7:0]            q_msb;
    logic [BURST_LOG2-1:0] wlow;       // position inside the current burst

    // Sample formatting for both packing modes
    assign i_wide = 16'(signed'(rx_i));
    assign q_wide = 16'(signed'(rx_q));
    assign i_msb  = rx_i[DW-1 -: 8];
    assign q_msb  = rx_q[DW-1 -: 8];
    assign wlow   = wcnt[BURST_LOG2-1:0];

    assign busy = (state != IDLE);

    // Capture FSM with registered stream outputs and word counter
    always_ff @(posedge Sclk or posedge rst) begin
        if (rst) begin
            // NOTE: every register here is a small control/data flop, so all of them
            // are reset; an abort mid-capture leaves nothing half-emitted.
            state    <= IDLE;
            mode_r   <= 1'b0;
            dec_r    <= 8'd0;
            dcnt     <= 8'd0;
            pend     <= 16'd0;
            pend_vld <= 1'b0;
            bus.Sout <= 32'd0;
            bus.Ien  <= 1'b0;
            bus.sync <= 1'b0;
            wcnt     <= 32'd0;
        end else begin
            // NOTE: strobes default low each cycle and are raised only where a word
            // or sync is produced; non-blocking assignments let the later, more
            // specific assignment win without ordering hazards.
            bus.Ien  <= 1'b0;
            bus.sync <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (en) begin
                        mode_r   <= mode;
                        dec_r    <= dec;
                        dcnt     <= 8'd0;
                        pend_vld <= 1'b0;
                        wcnt     <= 32'd0;
                        bus.sync <= 1'b1;
                        state    <= RUN;
                    end
                end

                RUN: begin
                    if (en) begin
                        if (rx_valid) begin
                            if (dcnt == 8'd0) begin
                                dcnt <= dec_r;
                                if (!mode_r) begin
                                    bus.Sout <= {q_wide, i_wide};
                                    bus.Ien  <= 1'b1;
                                    wcnt     <= wcnt + 32'd1;
                                end else if (!pend_vld) begin
                                    pend     <= {q_msb, i_msb};
                                    pend_vld <= 1'b1;
                                end else begin
                                    bus.Sout <= {q_msb, i_msb, pend};
                                    bus.Ien  <= 1'b1;
                                    wcnt     <= wcnt + 32'd1;
                                    pend_vld <= 1'b0;
                                end
                            end else begin
                                dcnt <= dcnt - 8'd1;
                            end
                        end
                    end else if (pend_vld) begin
                        // Flush the lone compressed sample, then pad the burst
                        bus.Sout <= {16'h0000, pend};
                        bus.Ien  <= 1'b1;
                        wcnt     <= wcnt + 32'd1;
                        pend_vld <= 1'b0;
                        state    <= DRAIN;
                    end else if (wlow == '0) begin
                        state <= IDLE;
                    end else begin
                        state <= DRAIN;
                    end
                end

                DRAIN: begin
                    // The pad that completes the burst also returns to IDLE,
                    // so DRAIN never spends an idle cycle after the last pad
                    if (wlow != '0) begin
                        bus.Sout <= 32'd0;
                        bus.Ien  <= 1'b1;
                        wcnt     <= wcnt + 32'd1;
                        if (&wlow) state <= IDLE;
                    end else begin
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
